// File: rtl/ad2s1210_spi_pkg.sv
// Shared types and constants for the AD2S1210 byte-serial SPI master.
// Build option: AD2S1210_SPI_READBACK_EN enables SDO capture.
package ad2s1210_spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_stream.sv
// Minimal AXI-stream bundle with valid/ready handshake.
// Producer side uses master, consumer side uses slave.
interface axi_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;

    modport master (
        output data, valid, dest, user,
        input  ready
    );

    modport slave (
        input  data, valid, dest, user,
        output ready
    );
endinterface

// File: rtl/ad2s1210_sclk_gen.sv
// SCLK generator: owns the half-period divider and the 7..0 bit counter.
// Strobes mark the edge at which sclk falls, rises, or the last bit ends.
module ad2s1210_sclk_gen #(
    parameter int DIV_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] divider,
    output logic             sclk,
    output logic             fall_strobe,
    output logic             rise_strobe,
    output logic             last_bit
);
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;
    logic [2:0]       bit_cnt;
    logic             first;
    logic             phase_end;

    assign div_last = divider - DIV_W'(1);

    // The idle-high level counts as a finished high phase, so the
    // first enabled cycle produces the opening falling edge.
    assign phase_end   = enable && (first || div_cnt == div_last);
    assign last_bit    = phase_end && sclk && !first && bit_cnt == 3'd0;
    assign fall_strobe = phase_end && sclk && !last_bit;
    assign rise_strobe = phase_end && !sclk;

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= 3'd7;
            first   <= 1'b1;
        end else if (phase_end) begin
            div_cnt <= '0;
            first   <= 1'b0;
            if (!last_bit) begin
                sclk <= ~sclk;
            end
            if (fall_strobe && !first) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ad2s1210_spi_master.sv
// Byte-serial SPI master for the AD2S1210, one byte per cs_n frame.
// Define AD2S1210_SPI_READBACK_EN to capture SDO onto data_out.
module ad2s1210_spi_master
    import ad2s1210_spi_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 4,
    parameter int CS_SETUP      = 2,
    parameter int CS_HOLD       = 2,
    parameter int GAP           = 4
) (
    input  logic      clock,
    input  logic      reset,
    axi_stream.slave  data_in,
    axi_stream.master data_out,
    output logic      sclk,
    output logic      mosi,
    input  logic      miso,
    output logic      cs_n
);
    localparam int DIV_W = $clog2(CLOCK_DIVIDER + 1);
    localparam int MAXP  = max3(CS_SETUP, CS_HOLD, GAP);
    localparam int PH_W  = $clog2(MAXP + 1);

    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP - 1);

    spi_state_t        state;
    logic [PH_W-1:0]   phase;
    logic [BYTE_W-1:0] tx;
    logic              ready_q;
    logic              gen_en;
    logic              fall;
    logic              rise;
    logic              last;
    logic              frame_end;

    assign data_in.ready = ready_q;

    assign gen_en = (state == S_SHIFT)
                 || (state == S_SETUP && phase == SETUP_LAST);

    assign frame_end = (state == S_HOLD) && (phase == HOLD_LAST);

    ad2s1210_sclk_gen #(
        .DIV_W(DIV_W)
    ) u_sclk_gen (
        .clock      (clock),
        .reset      (reset),
        .enable     (gen_en),
        .divider    (DIV_W'(CLOCK_DIVIDER)),
        .sclk       (sclk),
        .fall_strobe(fall),
        .rise_strobe(rise),
        .last_bit   (last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_IDLE;
            phase   <= '0;
            tx      <= '0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (data_in.valid) begin
                        tx      <= data_in.data[BYTE_W-1:0];
                        mosi    <= data_in.data[BYTE_W-1];
                        cs_n    <= 1'b0;
                        ready_q <= 1'b0;
                        phase   <= '0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase == SETUP_LAST) begin
                        phase <= '0;
                        state <= S_SHIFT;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_SHIFT: begin
                    // Refilling with the LSB keeps bit 0 on mosi after the last rise.
                    if (rise) begin
                        tx   <= {tx[BYTE_W-2:0], tx[0]};
                        mosi <= tx[BYTE_W-2];
                    end
                    if (last) begin
                        phase <= '0;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (frame_end) begin
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        phase <= '0;
                        state <= S_GAP;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_GAP: begin
                    if (phase == GAP_LAST) begin
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AD2S1210_SPI_READBACK_EN
    logic [BYTE_W-1:0] rx_shift;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == S_SHIFT && rise) begin
                rx_shift <= {rx_shift[BYTE_W-2:0], miso};
            end
            if (frame_end) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out.data = '0;
        data_out.data[BYTE_W-1:0] = rx_byte;
    end
    assign data_out.valid = rx_valid;

    logic unused_inputs;
    assign unused_inputs = ^{data_in.data, data_in.dest,
                             data_in.user, data_out.ready, fall};
`else
    assign data_out.data  = '0;
    assign data_out.valid = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{data_in.data, data_in.dest,
                             data_in.user, data_out.ready, fall, miso};
`endif

    assign data_out.dest = '0;
    assign data_out.user = '0;

endmodule
